// File: rtl/xheep2bridge_obi_resp.sv
// OBI responder that lets X-HEEP software queue 32-bit result words for the CW305 host.
// The host drains the queue via a first-word-fall-through pop port; STATUS exposes occupancy and flags.
module xheep2bridge_obi_resp #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             gnt,
  output logic             rvalid,
  output logic [31:0]      rdata,
  input  logic             host_pop,
  output logic [31:0]      host_data,
  output logic             host_valid,
  output logic [CNT_W-1:0] host_count,
  output logic             host_underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  wr_cnt_reg, rd_cnt_reg, count;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rdata_reg, rd_value, status_word, be_mask;
  logic              underflow_reg;
  logic              full, empty, sel_data, sel_status;
  logic              push, pop, underflow_evt, w1c;
  logic              unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};

  assign sel_data   = (addr[3:2] == 2'd0);
  assign sel_status = (addr[3:2] == 2'd1);

  // Read/write counters are one bit wider than the pointers so full and empty are distinct.
  assign count  = wr_cnt_reg - rd_cnt_reg;
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ptr = wr_cnt_reg[PTR_W-1:0];
  assign rd_ptr = rd_cnt_reg[PTR_W-1:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign be_mask[gi*8 +: 8] = {8{be[gi]}};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    gnt        = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt = req && !(we && sel_data && full);
        if (gnt) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign push          = gnt && we && sel_data;
  assign pop           = host_pop && !empty;
  assign underflow_evt = host_pop && empty;
  assign w1c           = gnt && we && sel_status && be[2] && wdata[18];

  always_comb begin
    status_word            = '0;
    status_word[CNT_W-1:0] = count;
    status_word[16]        = full;
    status_word[17]        = empty;
    status_word[18]        = underflow_reg;
  end

  assign rd_value = (!we && sel_status) ? status_word : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rdata_reg     <= '0;
      wr_cnt_reg    <= '0;
      rd_cnt_reg    <= '0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= gnt ? rd_value : '0;
      if (push) wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
      if (pop)  rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
      // A new underflow outranks a simultaneous clear so the event is never lost.
      if (underflow_evt)  underflow_reg <= 1'b1;
      else if (w1c)       underflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata & be_mask;
  end

  assign rvalid         = (state_reg == RESP);
  assign rdata          = rdata_reg;
  assign host_data      = mem[rd_ptr];
  assign host_valid     = !empty;
  assign host_count     = count;
  assign host_underflow = underflow_reg;

endmodule

// File: tb/tb_xheep2bridge_obi_resp.sv
// Directed bench for xheep2bridge_obi_resp: table of bus transactions plus hand sequences
// for backpressure, underflow/W1C, pointer wrap and mid-transaction reset.
module tb_xheep2bridge_obi_resp;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req, we, host_pop;
  logic [3:0]       be;
  logic [31:0]      addr, wdata;
  logic             gnt, rvalid, host_valid, host_underflow;
  logic [31:0]      rdata, host_data;
  logic [CNT_W-1:0] host_count;

  int n_vec = 0;
  int n_err = 0;

  xheep2bridge_obi_resp #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .host_pop(host_pop), .host_data(host_data),
    .host_valid(host_valid), .host_count(host_count), .host_underflow(host_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        pop;
    logic [31:0] exp_rdata;
    logic [31:0] exp_count;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Called aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic p, output logic [31:0] rd);
    int n;
    req = 1'b1; we = w; addr = a; be = b; wdata = d; host_pop = p;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    check("gnt", {31'd0, gnt}, 32'd1);
    check("rvalid_before_gnt_edge", {31'd0, rvalid}, 32'd0);
    rd = '0;
    if (!gnt) begin
      req = 1'b0; host_pop = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; host_pop = 1'b0;
    @(negedge clk);
    check("rvalid", {31'd0, rvalid}, 32'd1);
    rd = rdata;
    @(posedge clk); #1;
    check("rvalid_single", {31'd0, rvalid}, 32'd0);
  endtask

  task automatic pop_one();
    host_pop = 1'b1;
    @(posedge clk); #1;
    host_pop = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] model[$];

  initial begin
    vecs[0] = '{1'b1, 32'h0, 4'hF, 32'h11111111, 1'b0, 32'h0,        32'd1, 32'h11111111};
    vecs[1] = '{1'b1, 32'h0, 4'hF, 32'h22222222, 1'b0, 32'h0,        32'd2, 32'h11111111};
    vecs[2] = '{1'b1, 32'h0, 4'hF, 32'h33333333, 1'b0, 32'h0,        32'd3, 32'h11111111};
    vecs[3] = '{1'b0, 32'h4, 4'hF, 32'h0,        1'b0, 32'h00000003, 32'd3, 32'h11111111};
    vecs[4] = '{1'b1, 32'h0, 4'h3, 32'hAABBCCDD, 1'b0, 32'h0,        32'd4, 32'h11111111};
    vecs[5] = '{1'b1, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        32'd5, 32'h11111111};
    vecs[6] = '{1'b0, 32'h8, 4'hF, 32'h0,        1'b0, 32'h0,        32'd5, 32'h11111111};
    vecs[7] = '{1'b1, 32'hC, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'd5, 32'h11111111};
    vecs[8] = '{1'b0, 32'h0, 4'hF, 32'h0,        1'b0, 32'h0,        32'd5, 32'h11111111};
    vecs[9] = '{1'b1, 32'h0, 4'hC, 32'h44444444, 1'b1, 32'h0,        32'd5, 32'h22222222};

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; host_pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_host_valid", {31'd0, host_valid}, 32'd0);
    check("rst_host_count", 32'(host_count), 32'd0);
    check("rst_underflow", {31'd0, host_underflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].pop, rd);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_count", i), 32'(host_count), vecs[i].exp_count);
      check($sformatf("vec%0d_head", i), host_data, vecs[i].exp_head);
    end

    // Drain: order and byte-enable masking.
    model = '{32'h22222222, 32'h33333333, 32'h0000CCDD, 32'h00000000, 32'h44440000};
    foreach (model[i]) begin
      check($sformatf("drain%0d", i), host_data, model[i]);
      pop_one();
    end
    check("drained_valid", {31'd0, host_valid}, 32'd0);

    // Underflow, W1C with wrong byte lane, set-wins, proper clear.
    pop_one();
    check("underflow_set", {31'd0, host_underflow}, 32'd1);
    check("underflow_count", 32'(host_count), 32'd0);
    txn(1'b0, 32'h4, 4'hF, 32'h0, 1'b0, rd);
    check("status_underflow", rd, 32'h00060000);
    txn(1'b1, 32'h4, 4'hB, 32'h00040000, 1'b0, rd);
    check("w1c_be2_off", {31'd0, host_underflow}, 32'd1);
    txn(1'b1, 32'h4, 4'hF, 32'h00040000, 1'b1, rd);
    check("w1c_set_wins", {31'd0, host_underflow}, 32'd1);
    txn(1'b1, 32'h4, 4'hF, 32'h00040000, 1'b0, rd);
    check("w1c_clear", {31'd0, host_underflow}, 32'd0);
    txn(1'b0, 32'h4, 4'hF, 32'h0, 1'b0, rd);
    check("status_cleared", rd, 32'h00020000);

    // Fill to full, then backpressure a 9th write until a pop frees a slot.
    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'h0, 4'hF, 32'hA0000000 + i, 1'b0, rd);
    txn(1'b0, 32'h4, 4'hF, 32'h0, 1'b0, rd);
    check("status_full", rd, 32'h00010008);
    req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF; wdata = 32'hB9B9B9B9;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) host_pop = 1'b1;
      @(negedge clk);
      check($sformatf("full_gnt_c%0d", c), {31'd0, gnt}, 32'd0);
      @(posedge clk); #1;
      host_pop = 1'b0;
    end
    @(negedge clk);
    check("full_gnt_c6", {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    check("full_rvalid", {31'd0, rvalid}, 32'd1);
    check("full_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    check("full_count", 32'(host_count), 32'd8);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("full_drain%0d", i), host_data, 32'hA0000000 + i);
      pop_one();
    end
    check("full_drain_last", host_data, 32'hB9B9B9B9);
    pop_one();
    check("full_drained", {31'd0, host_valid}, 32'd0);

    // Interleaved push+pop at count 4 across pointer wrap.
    model.delete();
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 32'h0, 4'hF, 32'hC0000000 + i, 1'b0, rd);
      model.push_back(32'hC0000000 + i);
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ilv%0d_head", i), host_data, model[0]);
      txn(1'b1, 32'h0, 4'hF, 32'hD0000000 + i, 1'b1, rd);
      void'(model.pop_front());
      model.push_back(32'hD0000000 + i);
      check($sformatf("ilv%0d_count", i), 32'(host_count), 32'd4);
    end
    txn(1'b0, 32'h8, 4'hF, 32'h0, 1'b0, rd);
    check("addr8_rdata", rd, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ilv_drain%0d", i), host_data, model[i]);
      pop_one();
    end

    // Reset while in RESP with count 5.
    for (int i = 0; i < 5; i++) txn(1'b1, 32'h0, 4'hF, 32'hE0000000 + i, 1'b0, rd);
    check("pre_reset_count", 32'(host_count), 32'd5);
    req = 1'b1; we = 1'b0; addr = 32'h4; be = 4'hF;
    @(negedge clk);
    check("pre_reset_gnt", {31'd0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_count", 32'(host_count), 32'd0);
    check("mid_rst_valid", {31'd0, host_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
    txn(1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0, rd);
    check("post_rst_rdata", rd, 32'd0);
    check("post_rst_count", 32'(host_count), 32'd1);
    check("post_rst_head", host_data, 32'h5A5A5A5A);
    txn(1'b0, 32'h4, 4'hF, 32'h0, 1'b0, rd);
    check("post_rst_status", rd, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
